// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared AES datapath constants, block/word types and the helper
//           that selects one 32-bit word out of a 128-bit block.
// Revision: 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int AES_BLK_W         = 128;
  localparam int AES_WORD_W        = 32;
  localparam int AES_WORDS_PER_BLK = 4;
  localparam int AES_IDX_W         = 2;

  typedef logic [AES_BLK_W-1:0]  aes_block_t;
  typedef logic [AES_WORD_W-1:0] aes_word_t;
  typedef logic [AES_IDX_W-1:0]  aes_idx_t;

  // Word 0 is the most-significant word of the block.
  function automatic aes_word_t aes_word_sel(input aes_block_t blk, input aes_idx_t idx);
    aes_word_t w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_blk_fifo.sv
`default_nettype none
// ============================================================================
// Module  : aes_blk_fifo
// Brief   : DEPTH x 128-bit circular buffer with push/pop/flush and
//           occupancy count. Head entry is presented combinationally.
//           Callers never push when full nor pop when empty.
// Revision: 1.0 - initial release
// ============================================================================
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             iClk,
  input  logic             iReset_n,
  input  logic             iPush,
  input  logic             iPop,
  input  logic             iFlush,
  input  aes_block_t       iWrData,
  output aes_block_t       oRdData,
  output logic [CNT_W-1:0] oCount,
  output logic             oFull,
  output logic             oEmpty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  aes_block_t       mem_q [DEPTH];
  aes_block_t       mem_d [DEPTH];

  // Pointer and count update; power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (iFlush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (iPush) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (iPop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({iPush, iPop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage write; flush leaves contents alone since the count masks them.
  always_comb begin
    mem_d = mem_q;
    if (iPush && !iFlush) mem_d[wr_ptr_q] = iWrData;
  end

  // Control state register.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage register, no reset needed: never visible while unoccupied.
  always_ff @(posedge iClk) begin
    mem_q <= mem_d;
  end

  assign oRdData = mem_q[rd_ptr_q];
  assign oCount  = count_q;
  assign oFull   = (count_q == CNT_W'(DEPTH));
  assign oEmpty  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/aes_ct_unpacker.sv
`default_nettype none
// ============================================================================
// Module  : aes_ct_unpacker
// Brief   : Captures AES ciphertext blocks on the rising edge of the core's
//           done level, buffers DEPTH blocks and streams them as 32-bit
//           words (MSW first) on a show-ahead valid/ready interface.
//           Optional macro AES_CT_OVF_CNT_EN adds oOvfCount, a saturating
//           8-bit count of dropped blocks.
// Revision: 1.0 - initial release
// ============================================================================
module aes_ct_unpacker
  import aes_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             iClk,
  input  logic             iReset_n,
  input  logic             iBlkValid,
  input  logic [127:0]     iBlkData,
  input  logic             iFlush,
  output logic             oWordValid,
  output logic [31:0]      oWordData,
  output logic             oWordLast,
  input  logic             iWordReady,
  output logic [CNT_W-1:0] oCount,
  output logic             oEmpty,
  output logic             oFull,
  output logic             oOverflow
`ifdef AES_CT_OVF_CNT_EN
  ,
  output logic [7:0]       oOvfCount
`endif
);

  localparam aes_idx_t LAST_IDX = AES_IDX_W'(AES_WORDS_PER_BLK - 1);

  logic       blk_valid_q, blk_valid_d;
  aes_idx_t   idx_q,       idx_d;
  logic       ovf_q,       ovf_d;

  logic       blk_rise;
  logic       do_push;
  logic       do_drop;
  logic       do_xfer;
  logic       do_pop;
  aes_block_t head_blk;
  logic       fifo_full;
  logic       fifo_empty;

  aes_blk_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .iPush    (do_push),
    .iPop     (do_pop),
    .iFlush   (iFlush),
    .iWrData  (iBlkData),
    .oRdData  (head_blk),
    .oCount   (oCount),
    .oFull    (fifo_full),
    .oEmpty   (fifo_empty)
  );

  // Push/pop decisions; fullness is the registered count, so a pop in the
  // same cycle never rescues an incoming block.
  always_comb begin
    blk_rise = iBlkValid && !blk_valid_q;
    do_push  = blk_rise && !fifo_full && !iFlush;
    do_drop  = blk_rise &&  fifo_full && !iFlush;
    do_xfer  = !fifo_empty && iWordReady;
    do_pop   = do_xfer && (idx_q == LAST_IDX) && !iFlush;
  end

  // Edge-detect, word index and sticky overflow next-state.
  always_comb begin
    blk_valid_d = iBlkValid;
    idx_d       = idx_q;
    ovf_d       = ovf_q;
    if (iFlush) begin
      idx_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (do_xfer) idx_d = idx_q + AES_IDX_W'(1);
      if (do_drop) ovf_d = 1'b1;
    end
  end

  // Top-level state register.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      blk_valid_q <= 1'b0;
      idx_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      blk_valid_q <= blk_valid_d;
      idx_q       <= idx_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef AES_CT_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating dropped-block counter, stepped by the same event as the flag.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (iFlush)                            ovf_cnt_d = '0;
    else if (do_drop && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  // Dropped-block counter register.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) ovf_cnt_q <= '0;
    else           ovf_cnt_q <= ovf_cnt_d;
  end

  assign oOvfCount = ovf_cnt_q;
`endif

  // Show-ahead outputs; data is forced to zero when nothing is held.
  assign oWordValid = !fifo_empty;
  assign oWordData  = fifo_empty ? '0 : aes_word_sel(head_blk, idx_q);
  assign oWordLast  = !fifo_empty && (idx_q == LAST_IDX);
  assign oEmpty     = fifo_empty;
  assign oFull      = fifo_full;
  assign oOverflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_ct_unpacker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_aes_ct_unpacker
// Brief   : Self-checking bench for aes_ct_unpacker (DEPTH=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_ct_unpacker;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic              iClk       = 1'b0;
  logic              iReset_n   = 1'b0;
  logic              iBlkValid  = 1'b0;
  logic [127:0]      iBlkData   = '0;
  logic              iFlush     = 1'b0;
  logic              iWordReady = 1'b0;
  logic              oWordValid;
  logic [31:0]       oWordData;
  logic              oWordLast;
  logic [CNT_W-1:0]  oCount;
  logic              oEmpty;
  logic              oFull;
  logic              oOverflow;
`ifdef AES_CT_OVF_CNT_EN
  logic [7:0]        oOvfCount;
`endif

  aes_ct_unpacker #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .iClk       (iClk),
    .iReset_n   (iReset_n),
    .iBlkValid  (iBlkValid),
    .iBlkData   (iBlkData),
    .iFlush     (iFlush),
    .oWordValid (oWordValid),
    .oWordData  (oWordData),
    .oWordLast  (oWordLast),
    .iWordReady (iWordReady),
    .oCount     (oCount),
    .oEmpty     (oEmpty),
    .oFull      (oFull),
    .oOverflow  (oOverflow)
`ifdef AES_CT_OVF_CNT_EN
    ,
    .oOvfCount  (oOvfCount)
`endif
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [127:0] blk;
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic [31:0]  w2;
    logic [31:0]  w3;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic expect_blk(input logic [127:0] b);
    for (int i = 0; i < 4; i++)
      sb_q.push_back({b[127-32*i -: 32], (i == 3)});
  endtask

  task automatic pulse_blk(input logic [127:0] b, input bit accepted);
    iBlkData  = b;
    iBlkValid = 1'b1;
    if (accepted) expect_blk(b);
    tick();
    iBlkValid = 1'b0;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && sb_q.size() != 0; i++) tick();
    chk("drain_done", 128'(sb_q.size()), 128'd0);
  endtask

  function automatic logic [127:0] rnd_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Scoreboard: every accepted word is compared against the queue head.
  always @(negedge iClk) begin
    exp_t e;
    if (iReset_n && !iFlush && oWordValid && iWordReady) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)", oWordData, $time);
      end else begin
        e = sb_q.pop_front();
        chk("word_data", 128'(oWordData), 128'(e.data));
        chk("word_last", 128'(oWordLast), 128'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [3];
    logic [127:0] b;
    int         budget;

    vecs[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF,
                32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    vecs[1] = '{128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A,
                32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A};
    vecs[2] = '{128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D,
                32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_valid",  128'(oWordValid), 128'd0);
    chk("rst_data",   128'(oWordData),  128'd0);
    chk("rst_last",   128'(oWordLast),  128'd0);
    chk("rst_count",  128'(oCount),     128'd0);
    chk("rst_empty",  128'(oEmpty),     128'd1);
    chk("rst_full",   128'(oFull),      128'd0);
    chk("rst_ovf",    128'(oOverflow),  128'd0);
`ifdef AES_CT_OVF_CNT_EN
    chk("rst_ovfcnt", 128'(oOvfCount),  128'd0);
`endif
    iReset_n = 1'b1;
    tick();

    // ---- table-driven single blocks, full-rate read ----
    iWordReady = 1'b1;
    for (int v = 0; v < 3; v++) begin
      iBlkData  = vecs[v].blk;
      iBlkValid = 1'b1;
      sb_q.push_back({vecs[v].w0, 1'b0});
      sb_q.push_back({vecs[v].w1, 1'b0});
      sb_q.push_back({vecs[v].w2, 1'b0});
      sb_q.push_back({vecs[v].w3, 1'b1});
      tick();
      chk("latency_valid", 128'(oWordValid), 128'd1);
      chk("latency_word0", 128'(oWordData),  128'(vecs[v].w0));
      iBlkValid = 1'b0;
      repeat (4) tick();
      chk("four_cycles_empty", 128'(oEmpty), 128'd1);
      chk("four_cycles_sb",    128'(sb_q.size()), 128'd0);
    end

    // ---- held-high level gives exactly one push ----
    iWordReady = 1'b0;
    iBlkData   = vecs[2].blk;
    iBlkValid  = 1'b1;
    expect_blk(vecs[2].blk);
    repeat (10) tick();
    chk("held_count", 128'(oCount), 128'd1);
    iWordReady = 1'b1;
    drain();
    repeat (3) tick();
    chk("held_empty", 128'(oEmpty), 128'd1);
    iBlkValid = 1'b0;
    tick();

    // ---- back-pressure holds word 1 ----
    iBlkData  = vecs[0].blk;
    iBlkValid = 1'b1;
    expect_blk(vecs[0].blk);
    tick();
    iBlkValid = 1'b0;
    tick();
    iWordReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", 128'(oWordData), 128'h44556677);
      tick();
    end
    iWordReady = 1'b1;
    drain();

    // ---- five pulses into DEPTH=4, no reads ----
    iWordReady = 1'b0;
    for (int i = 0; i < 5; i++) pulse_blk(rnd_blk(), i < 4);
    chk("ovf_full",  128'(oFull),     128'd1);
    chk("ovf_count", 128'(oCount),    128'd4);
    chk("ovf_flag",  128'(oOverflow), 128'd1);
`ifdef AES_CT_OVF_CNT_EN
    chk("ovf_cnt",   128'(oOvfCount), 128'd1);
`endif
    iWordReady = 1'b1;
    drain();
    chk("ovf_sticky", 128'(oOverflow), 128'd1);
    chk("ovf_empty",  128'(oEmpty),    128'd1);

    // ---- push while full coinciding with word-3 acceptance ----
    iFlush = 1'b1;
    tick();
    iFlush = 1'b0;
    chk("flush_clr_ovf", 128'(oOverflow), 128'd0);
    iWordReady = 1'b0;
    for (int i = 0; i < 4; i++) pulse_blk(rnd_blk(), 1'b1);
    chk("full_before", 128'(oFull), 128'd1);
    iWordReady = 1'b1;
    budget = 0;
    while (!oWordLast && budget < 10) begin
      tick();
      budget++;
    end
    chk("reach_last", 128'(oWordLast), 128'd1);
    iBlkData  = rnd_blk();
    iBlkValid = 1'b1;
    tick();
    iBlkValid = 1'b0;
    chk("coinc_count", 128'(oCount),    128'd3);
    chk("coinc_ovf",   128'(oOverflow), 128'd1);
`ifdef AES_CT_OVF_CNT_EN
    chk("coinc_ovfcnt", 128'(oOvfCount), 128'd1);
`endif
    drain();

    // ---- flush during word 2 of A with B queued ----
    iWordReady = 1'b0;
    b = 128'h11111111_22222222_33333333_44444444;
    pulse_blk(b, 1'b1);
    pulse_blk(rnd_blk(), 1'b1);
    iWordReady = 1'b1;
    tick();
    tick();
    chk("flush_at_w2", 128'(oWordData), 128'h33333333);
    iFlush = 1'b1;
    sb_q.delete();
    tick();
    iFlush = 1'b0;
    chk("flush_empty", 128'(oEmpty),     128'd1);
    chk("flush_ovf",   128'(oOverflow),  128'd0);
    chk("flush_count", 128'(oCount),     128'd0);
    chk("flush_data",  128'(oWordData),  128'd0);
    b = rnd_blk();
    iBlkData  = b;
    iBlkValid = 1'b1;
    expect_blk(b);
    tick();
    chk("post_flush_w0", 128'(oWordData), 128'(b[127:96]));
    iBlkValid = 1'b0;
    drain();

    // ---- reset mid-read ----
    pulse_blk(vecs[1].blk, 1'b1);
    tick();
    iReset_n = 1'b0;
    sb_q.delete();
    #1;
    chk("mid_rst_valid", 128'(oWordValid), 128'd0);
    chk("mid_rst_data",  128'(oWordData),  128'd0);
    chk("mid_rst_last",  128'(oWordLast),  128'd0);
    chk("mid_rst_count", 128'(oCount),     128'd0);
    chk("mid_rst_empty", 128'(oEmpty),     128'd1);
    chk("mid_rst_full",  128'(oFull),      128'd0);
`ifdef AES_CT_OVF_CNT_EN
    chk("mid_rst_ovfcnt", 128'(oOvfCount), 128'd0);
`endif
    tick();
    tick();
    iReset_n = 1'b1;
    repeat (6) tick();
    chk("post_rst_quiet", 128'(oWordValid), 128'd0);
    pulse_blk(vecs[0].blk, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
